// File: rtl/regfile_arbiter_pkg.sv
// rtl/regfile_arbiter_pkg.sv - shared types and constants for the register-file arbiter
package regfile_arbiter_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int REQ_EXE    = 0;
    localparam int REQ_DBG    = 1;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic is_read;
    } rsp_s1_t;

    typedef struct packed {
        logic valid;
        logic id;
    } rsp_s2_t;

    function automatic logic [1:0] req_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester-side command/response bundle of the arbiter
interface regfile_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [1:0]          req;
    logic [1:0]          lock;
    logic [1:0]          we;
    logic [1:0]          waddr;
    logic [1:0]          raddr0;
    logic [1:0]          raddr1;
    logic [2*DATA_W-1:0] wdata;
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [DATA_W-1:0]   rdata0;
    logic [DATA_W-1:0]   rdata1;

    modport master (
        output req, lock, we, waddr, raddr0, raddr1, wdata,
        input  gnt, rvalid, rdata0, rdata1
    );

    modport slave (
        input  req, lock, we, waddr, raddr0, raddr1, wdata,
        output gnt, rvalid, rdata0, rdata1
    );
endinterface

// File: rtl/regfile_arbiter_rr_lock_arb.sv
// rtl/regfile_arbiter_rr_lock_arb.sv - round-robin two-way arbiter with bounded ownership lock
module rr_lock_arb
    import regfile_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             last;
    logic             last_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;
    logic             own_id;
    logic             expired;

    assign own_id  = (state == OWN1);
    assign expired = (lock_cnt == CNT_W'(LOCK_MAX));

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state    <= ARB;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        lock_cnt_nxt = lock_cnt;
        case (state)
            ARB: begin
                if (|gnt) begin
                    last_nxt = gnt[1];
                    if (lock[gnt[1]]) begin
                        state_nxt    = gnt[1] ? OWN1 : OWN0;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            OWN0, OWN1: begin
                // Forced release hands the next tie to the other requester.
                if (expired) begin
                    state_nxt    = ARB;
                    last_nxt     = own_id;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    if (|gnt) begin
                        last_nxt = own_id;
                    end
                    if (!lock[own_id]) begin
                        state_nxt    = ARB;
                        lock_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt    = ARB;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (state)
                ARB: begin
                    case (req)
                        2'b01:   gnt = 2'b01;
                        2'b10:   gnt = 2'b10;
                        2'b11:   gnt = last ? 2'b01 : 2'b10;
                        default: gnt = 2'b00;
                    endcase
                end
                OWN0, OWN1: begin
                    if (!expired && req[own_id]) begin
                        gnt = req_onehot(own_id);
                    end
                end
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - shares the 2x8 register file between EXE and debug requesters
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic              sysclk,
    input  logic              rst,
    regfile_arbiter_if.slave  bus,
    output logic              rf_rw,
    output logic              rf_wsel,
    output logic [1:0]        rf_rsel,
    output logic [DATA_W-1:0] rf_w,
    input  logic [DATA_W-1:0] rf_read0,
    input  logic [DATA_W-1:0] rf_read1
);

    logic [1:0]        gnt;
    logic              gnt_any;
    logic              gnt_id;
    logic              sel_we;
    logic              sel_waddr;
    logic              sel_raddr0;
    logic              sel_raddr1;
    logic [DATA_W-1:0] sel_wdata;
    rsp_s1_t           s1;
    rsp_s2_t           s2;

    rr_lock_arb #(
        .LOCK_MAX (LOCK_MAX),
        .CNT_W    (CNT_W)
    ) u_arb (
        .sysclk (sysclk),
        .rst    (rst),
        .req    (bus.req),
        .lock   (bus.lock),
        .gnt    (gnt)
    );

    assign bus.gnt = gnt;
    assign gnt_any = |gnt;
    assign gnt_id  = gnt[REQ_DBG];

    assign sel_we     = bus.we[gnt_id];
    assign sel_waddr  = bus.waddr[gnt_id];
    assign sel_raddr0 = bus.raddr0[gnt_id];
    assign sel_raddr1 = bus.raddr1[gnt_id];
    assign sel_wdata  = gnt_id ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];

    // Idle cycles issue a harmless read and keep the last address/data on the pins.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            rf_rw   <= 1'b0;
            rf_wsel <= 1'b0;
            rf_rsel <= 2'b11;
            rf_w    <= '0;
        end else if (gnt_any) begin
            rf_rw   <= sel_we;
            rf_wsel <= sel_waddr;
            rf_rsel <= {~sel_raddr1, ~sel_raddr0};
            rf_w    <= sel_wdata;
        end else begin
            rf_rw   <= 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1.valid   <= gnt_any;
            s1.id      <= gnt_id;
            s1.is_read <= gnt_any & ~sel_we;
            s2.valid   <= s1.valid & s1.is_read;
            s2.id      <= s1.id;
        end
    end

    assign bus.rvalid = s2.valid ? req_onehot(s2.id) : 2'b00;
    assign bus.rdata0 = rf_read0;
    assign bus.rdata1 = rf_read1;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed self-checking bench for regfile_arbiter
module tb_regfile_arbiter;
    import regfile_arbiter_pkg::*;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       rf_rw;
    logic       rf_wsel;
    logic [1:0] rf_rsel;
    logic [7:0] rf_w;
    logic [7:0] rf_read0 = 8'h00;
    logic [7:0] rf_read1 = 8'h00;
    logic [7:0] rf_mem [2];

    int n_tests = 0;
    int n_fail  = 0;

    regfile_arbiter_if #(.DATA_W(8)) bus ();

    regfile_arbiter #(.DATA_W(8), .LOCK_MAX(8), .CNT_W(4)) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .bus      (bus),
        .rf_rw    (rf_rw),
        .rf_wsel  (rf_wsel),
        .rf_rsel  (rf_rsel),
        .rf_w     (rf_w),
        .rf_read0 (rf_read0),
        .rf_read1 (rf_read1)
    );

    always #5 sysclk = ~sysclk;

    // Register file: registered read ports, no reset, one command per cycle.
    initial begin
        rf_mem[0] = 8'h00;
        rf_mem[1] = 8'h00;
    end

    always @(posedge sysclk) begin
        if (rf_rw === 1'b1) begin
            rf_mem[rf_wsel] <= rf_w;
        end else begin
            rf_read0 <= rf_rsel[0] ? rf_mem[0] : rf_mem[1];
            rf_read1 <= rf_rsel[1] ? rf_mem[0] : rf_mem[1];
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic clr();
        bus.req    = 2'b00;
        bus.lock   = 2'b00;
        bus.we     = 2'b00;
        bus.waddr  = 2'b00;
        bus.raddr0 = 2'b00;
        bus.raddr1 = 2'b00;
        bus.wdata  = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] exp_g [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clr();
        tick();
        tick();
        bus.req = 2'b11;
        #1;
        chk("rst_gnt", bus.gnt, 2'b00);
        chk("rst_rvalid", bus.rvalid, 2'b00);
        chk("rst_rf_rw", rf_rw, 1'b0);
        chk("rst_rf_rsel", rf_rsel, 2'b11);
        chk("rst_rf_wsel", rf_wsel, 1'b0);
        chk("rst_rf_w", rf_w, 8'h00);
        clr();
        rst = 1'b0;

        // write S0=A5 then read S0/S1
        bus.req = 2'b01; bus.we = 2'b01; bus.waddr = 2'b00; bus.wdata = 16'h00A5;
        #1;
        chk("t1_wr_gnt", bus.gnt, 2'b01);
        tick();
        bus.we = 2'b00; bus.raddr0 = 2'b00; bus.raddr1 = 2'b01;
        #1;
        chk("t1_rd_gnt", bus.gnt, 2'b01);
        chk("t1_rf_rw_wr", rf_rw, 1'b1);
        chk("t1_rf_w", rf_w, 8'hA5);
        chk("t1_rf_wsel", rf_wsel, 1'b0);
        tick();
        clr();
        #1;
        chk("t1_rvalid_early", bus.rvalid, 2'b00);
        chk("t1_rf_rw_rd", rf_rw, 1'b0);
        chk("t1_rf_rsel", rf_rsel, 2'b01);
        tick();
        chk("t1_rvalid", bus.rvalid, 2'b01);
        chk("t1_rdata0", bus.rdata0, 8'hA5);
        chk("t1_rdata1", bus.rdata1, 8'h00);

        // tie alternation after reset, reads only
        do_reset();
        bus.raddr0 = 2'b10; bus.raddr1 = 2'b10;
        exp_g = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
        for (int k = 0; k < 6; k++) begin
            bus.req = (k < 4) ? 2'b11 : 2'b00;
            #1;
            chk($sformatf("t2_gnt_%0d", k), bus.gnt, exp_g[k+2]);
            chk($sformatf("t2_rvalid_%0d", k), bus.rvalid, exp_g[k]);
            if (exp_g[k] == 2'b01) chk($sformatf("t2_rdata0_%0d", k), bus.rdata0, 8'hA5);
            if (exp_g[k] == 2'b10) chk($sformatf("t2_rdata0_%0d", k), bus.rdata0, 8'h00);
            tick();
        end

        // req1 locked writes to S1; forced release after 8 cycles
        clr();
        bus.req = 2'b10; bus.lock = 2'b10; bus.we = 2'b10; bus.waddr = 2'b10; bus.wdata = 16'h1000;
        #1;
        chk("t3_lock_gnt", bus.gnt, 2'b10);
        tick();
        for (int k = 1; k < 8; k++) begin
            bus.req = 2'b11;
            bus.wdata = {8'h10 + 8'(k), 8'h00};
            #1;
            chk($sformatf("t3_own_gnt_%0d", k), bus.gnt, 2'b10);
            tick();
        end
        #1;
        chk("t3_forced_gnt", bus.gnt, 2'b00);
        tick();
        #1;
        chk("t3_after_gnt", bus.gnt, 2'b01);
        tick();

        // locked read-modify-write of S1
        clr();
        bus.req = 2'b10; bus.lock = 2'b10; bus.raddr0 = 2'b10;
        #1;
        chk("t4_rd_gnt", bus.gnt, 2'b10);
        tick();
        bus.req = 2'b01;
        #1;
        chk("t4_blocked", bus.gnt, 2'b00);
        tick();
        chk("t4_rvalid", bus.rvalid, 2'b10);
        chk("t4_rdata0", bus.rdata0, 8'h17);
        bus.req = 2'b10; bus.lock = 2'b00; bus.we = 2'b10; bus.waddr = 2'b10;
        bus.wdata = {bus.rdata0 + 8'h01, 8'h00};
        #1;
        chk("t4_wr_gnt", bus.gnt, 2'b10);
        tick();
        clr();
        bus.req = 2'b11; bus.raddr0 = 2'b01;
        #1;
        chk("t4_arb_gnt", bus.gnt, 2'b01);
        tick();
        clr();
        tick();
        chk("t4_rvalid2", bus.rvalid, 2'b01);
        chk("t4_rdata_inc", bus.rdata0, 8'h18);

        // write S1=3C then read S1 next cycle from the other requester
        bus.req = 2'b01; bus.we = 2'b01; bus.waddr = 2'b01; bus.wdata = 16'h003C;
        #1;
        chk("t5_wr_gnt", bus.gnt, 2'b01);
        tick();
        clr();
        bus.req = 2'b10; bus.raddr1 = 2'b10;
        #1;
        chk("t5_rd_gnt", bus.gnt, 2'b10);
        tick();
        clr();
        tick();
        chk("t5_rvalid", bus.rvalid, 2'b10);
        chk("t5_rdata1", bus.rdata1, 8'h3C);

        // reset right after a read grant drops the response
        bus.req = 2'b01;
        #1;
        chk("t6_rd_gnt", bus.gnt, 2'b01);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", bus.gnt, 2'b00);
        tick();
        rst = 1'b0;
        clr();
        #1;
        chk("t6_rvalid_a", bus.rvalid, 2'b00);
        chk("t6_rf_rw", rf_rw, 1'b0);
        chk("t6_rf_rsel", rf_rsel, 2'b11);
        tick();
        chk("t6_rvalid_b", bus.rvalid, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
